// File: rtl/pp_accumulator.sv
// Booth partial-product accumulator: sums 13 pre-aligned rows into a 48-bit mantissa product.
// Optional macro PP_ACCUMULATOR_CSA_EN folds two rows per cycle through a 3:2 compressor.

package fpu_defs_fmac;
    localparam int unsigned C_MANT = 23;
endpackage

module pp_accumulator
    import fpu_defs_fmac::*;
(
    input  logic                             Clk_CI,
    input  logic                             Rst_RBI,
    input  logic [12:0][2*C_MANT+2:0]        Pp_index_DI,
    input  logic                             Valid_SI,
    output logic                             Ready_SO,
    input  logic                             Flush_SI,
    output logic [2*C_MANT+1:0]              Product_DO,
    output logic                             Valid_SO,
    input  logic                             Ready_SI
);

    localparam int unsigned NUM_PP = 13;
    localparam int unsigned PP_W   = 2*C_MANT+3;

`ifdef PP_ACCUMULATOR_CSA_EN
    localparam logic [3:0] LAST_STEP = 4'd6;
`else
    localparam logic [3:0] LAST_STEP = 4'd12;
`endif

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

    state_e                         state_q, state_d;
    logic [NUM_PP-1:0][PP_W-1:0]    rows_q;
    logic [PP_W-1:0]                acc_q, acc_nxt;
    logic [3:0]                     cnt_q;
    logic                           capture, step, last_step;

    assign last_step = (cnt_q == LAST_STEP);

`ifdef PP_ACCUMULATOR_CSA_EN
    // Row 13 of the padded view is zero, so the final step adds row 12 alone.
    logic [NUM_PP:0][PP_W-1:0] rows_pad;
    logic [3:0]                idx_lo, idx_hi;
    logic [PP_W-1:0]           row_a, row_b, csa_sum, csa_maj;

    assign rows_pad = {{PP_W{1'b0}}, rows_q};
    assign idx_lo   = {cnt_q[2:0], 1'b0};
    assign idx_hi   = {cnt_q[2:0], 1'b1};
    assign row_a    = rows_pad[idx_lo];
    assign row_b    = rows_pad[idx_hi];
    assign csa_sum  = acc_q ^ row_a ^ row_b;
    assign csa_maj  = (acc_q & row_a) | (acc_q & row_b) | (row_a & row_b);
    assign acc_nxt  = csa_sum + {csa_maj[PP_W-2:0], 1'b0};
`else
    assign acc_nxt  = acc_q + rows_q[cnt_q];
`endif

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        step     = 1'b0;
        Ready_SO = 1'b0;
        Valid_SO = 1'b0;
        case (state_q)
            IDLE: begin
                Ready_SO = 1'b1;
                if (Valid_SI) begin
                    capture = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                step = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                Valid_SO = 1'b1;
                if (Ready_SI) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides everything, including a simultaneous accept.
        if (Flush_SI) begin
            state_d = IDLE;
            capture = 1'b0;
            step    = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            rows_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (Flush_SI) begin
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (capture) begin
            rows_q <= Pp_index_DI;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (step) begin
            acc_q  <= acc_nxt;
            cnt_q  <= last_step ? 4'd0 : cnt_q + 4'd1;
        end
    end

    // Bit 48 only collects sign/hot-one carries that cancel; drop it.
    assign Product_DO = Valid_SO ? acc_q[PP_W-2:0] : '0;

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed bench for pp_accumulator: Booth rows are built from mantissa pairs, products checked against a*b.
module tb_pp_accumulator;
    import fpu_defs_fmac::*;

`ifdef PP_ACCUMULATOR_CSA_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 13;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic [12:0][2*C_MANT+2:0]  pp;
    logic                       valid_in, ready_out, flush, valid_out, ready_in;
    logic [2*C_MANT+1:0]        product;

    int n_chk  = 0;
    int n_pass = 0;

    pp_accumulator dut (
        .Clk_CI      (clk),
        .Rst_RBI     (rst_n),
        .Pp_index_DI (pp),
        .Valid_SI    (valid_in),
        .Ready_SO    (ready_out),
        .Flush_SI    (flush),
        .Product_DO  (product),
        .Valid_SO    (valid_out),
        .Ready_SI    (ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Radix-4 Booth row i of unsigned a*b, sign-extended to 49 bits and shifted into place.
    function automatic logic [48:0] booth_row(input logic [23:0] a, input logic [23:0] b, input int i);
        logic [26:0] bx;
        int          d;
        logic [48:0] m;
        bx = {2'b00, b, 1'b0};
        d  = int'(bx[2*i+1]) + int'(bx[2*i]) - 2 * int'(bx[2*i+2]);
        m  = 49'(a) * 49'((d < 0) ? -d : d);
        m  = m << (2*i);
        if (d < 0) m = ~m + 49'd1;
        return m;
    endfunction

    task automatic load_rows(input logic [23:0] a, input logic [23:0] b);
        for (int i = 0; i < 13; i++) pp[i] = booth_row(a, b, i);
    endtask

    task automatic scramble_rows();
        for (int i = 0; i < 13; i++) pp[i] = 49'({$urandom(), $urandom()});
    endtask

    task automatic start_op(input string tag, input logic [23:0] a, input logic [23:0] b);
        int k;
        k = 0;
        while (!ready_out && k < 50) begin
            tick();
            k++;
        end
        chk({tag, "_ready"}, ready_out, 1'b1);
        load_rows(a, b);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        scramble_rows();
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_out && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [47:0] exp);
        int lat;
        start_op(tag, a, b);
        wait_valid(lat);
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_product"}, product, exp);
        tick();
        chk({tag, "_pulse_len"}, valid_out, 1'b0);
        chk({tag, "_ready_after"}, ready_out, 1'b1);
    endtask

    task automatic quiet_window(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid_out) seen++;
        end
        chk({tag, "_no_valid"}, seen, 0);
    endtask

    initial begin
        int          lat;
        logic [23:0] ra, rb;
        logic [47:0] rexp;
        int          stall;

        valid_in = 1'b0;
        flush    = 1'b0;
        ready_in = 1'b1;
        pp       = '0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", ready_out, 1'b1);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_product", product, 48'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        do_op("p8x8", 24'h800000, 24'h800000, 48'h400000000000);
        do_op("pFxF", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
        do_op("p8xF", 24'h800000, 24'hFFFFFF, 48'h7FFFFF800000);
        do_op("pFx8", 24'hFFFFFF, 24'h800000, 48'h7FFFFF800000);
        do_op("pAx9", 24'hA00000, 24'h900000, 48'h5A0000000000);

        // Downstream stall in DONE
        ready_in = 1'b0;
        start_op("stall", 24'hFFFFFF, 24'hFFFFFF);
        wait_valid(lat);
        chk("stall_latency", lat, LAT);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", valid_out, 1'b1);
            chk("stall_product", product, 48'hFFFFFE000001);
            chk("stall_ready_low", ready_out, 1'b0);
            tick();
        end
        ready_in = 1'b1;
        tick();
        chk("stall_release_ready", ready_out, 1'b1);
        chk("stall_release_valid", valid_out, 1'b0);

        // Flush during ACC
        start_op("flush", 24'hFFFFFF, 24'hFFFFFF);
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", ready_out, 1'b1);
        chk("flush_valid", valid_out, 1'b0);
        chk("flush_product", product, 48'h0);
        quiet_window("flush");
        do_op("pCxC", 24'hC00000, 24'hC00000, 48'h900000000000);

        // Flush together with Valid_SI in IDLE: nothing captured
        load_rows(24'h800000, 24'h800000);
        valid_in = 1'b1;
        flush    = 1'b1;
        tick();
        valid_in = 1'b0;
        flush    = 1'b0;
        chk("flush_accept_ready", ready_out, 1'b1);
        quiet_window("flush_accept");

        // Reset mid-ACC
        start_op("midrst", 24'hFFFFFF, 24'h800000);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready_out, 1'b1);
        chk("midrst_valid", valid_out, 1'b0);
        chk("midrst_product", product, 48'h0);
        tick();
        rst_n = 1'b1;
        quiet_window("midrst");
        chk("midrst_ready_after", ready_out, 1'b1);
        do_op("post_rst", 24'hC00000, 24'h800000, 48'h600000000000);

        // Random mantissas with random idle gaps and downstream stalls
        for (int n = 0; n < 30; n++) begin
            ra   = 24'($urandom()) | 24'h800000;
            rb   = 24'($urandom()) | 24'h800000;
            rexp = 48'(ra) * 48'(rb);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            ready_in = 1'b0;
            start_op("rand", ra, rb);
            wait_valid(lat);
            chk("rand_latency", lat, LAT);
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) tick();
            chk("rand_product", product, rexp);
            ready_in = 1'b1;
            tick();
            chk("rand_valid_drop", valid_out, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
